// File: rtl/vga_digit_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vga_digit_update_ctrl_pkg
//   Definitions shared by the digit update controller and the text unit:
//   FSM state encoding, the blank glyph code, default sizes and the
//   double-dabble nibble correction helper.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package vga_digit_update_ctrl_pkg;

  localparam int IN_W_DEFAULT   = 16;
  localparam int DIGITS_DEFAULT = 5;

  // Glyph code the text unit renders as an empty cell.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CONVERT = 3'd2,
    ST_WAIT_VS = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  // Double-dabble correction: a nibble of 5..9 gets 3 added so that the
  // following left shift carries correctly into the next decimal digit.
  // Input never exceeds 9, so the 4-bit sum never overflows.
  function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/vga_digit_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_digit_update_ctrl_if
//   Bundles the value strobe, vsync and the committed-digit outputs of the
//   digit update controller.
//   Signals:
//     value        binary value to display
//     value_valid  1-cycle strobe, value is new
//     vsync        vsync from vga_sync, synchronous to clk
//     bcd_digits   committed digits {d[DIGITS-1]..d[0]}
//     busy         conversion in progress or commit pending
//     update_done  1-cycle pulse when bcd_digits changes
//   Modports: master (value source / digit consumer), slave (controller).
// ---------------------------------------------------------------------------
interface vga_digit_update_ctrl_if
  import vga_digit_update_ctrl_pkg::*;
#(
  parameter int IN_W   = IN_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
);

  logic [IN_W-1:0]     value;
  logic                value_valid;
  logic                vsync;
  logic [4*DIGITS-1:0] bcd_digits;
  logic                busy;
  logic                update_done;

  modport master (
    output value, value_valid, vsync,
    input  bcd_digits, busy, update_done
  );

  modport slave (
    input  value, value_valid, vsync,
    output bcd_digits, busy, update_done
  );

endinterface

// File: rtl/vga_digit_update_ctrl_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// vga_digit_update_ctrl_bin2bcd_seq
//   Iterative double-dabble converter, one bit per cycle.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     start       load src and begin a conversion (restarts any running one)
//     src         binary value to convert
//     done        high during the final iteration; result is valid from the
//                 following cycle and held until the next start
//     result      BCD digits {d[DIGITS-1]..d[0]}
// ---------------------------------------------------------------------------
module vga_digit_update_ctrl_bin2bcd_seq
  import vga_digit_update_ctrl_pkg::*;
#(
  parameter int IN_W   = IN_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_W-1:0]     src,
  output logic                done,
  output logic [4*DIGITS-1:0] result
);

  localparam int SW = 4*DIGITS + IN_W;
  localparam int IW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'(IN_W - 1);

  logic [SW-1:0] shift_reg;
  logic [SW-1:0] adjusted;
  logic [IW-1:0] iter;
  logic          running;

  // Only the BCD field gets corrected; the binary field below it just shifts.
  always_comb begin
    adjusted = shift_reg;
    for (int k = 0; k < DIGITS; k++) begin
      adjusted[IN_W + 4*k +: 4] = add3_nibble(shift_reg[IN_W + 4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      iter      <= '0;
      running   <= 1'b0;
    end else if (start) begin
      shift_reg <= {{(4*DIGITS){1'b0}}, src};
      iter      <= '0;
      running   <= 1'b1;
    end else if (running) begin
      shift_reg <= {adjusted[SW-2:0], 1'b0};
      iter      <= iter + IW'(1);
      if (iter == LAST_ITER) begin
        running <= 1'b0;
      end
    end
  end

  assign done   = running && (iter == LAST_ITER);
  assign result = shift_reg[SW-1 -: 4*DIGITS];

endmodule

// File: rtl/vga_digit_update_ctrl.sv
// ---------------------------------------------------------------------------
// vga_digit_update_ctrl
//   Converts a binary mouse value to BCD digits and commits them to the text
//   unit only on a vsync assertion edge, so a frame never mixes old and new
//   digits. A value arriving while busy is held (latest wins) and converted
//   after the current commit.
//   Ports:
//     clk    system clock (same as vga_sync)
//     rst_n  asynchronous active-low reset
//     bus    slave side of vga_digit_update_ctrl_if (value, value_valid,
//            vsync in; bcd_digits, busy, update_done out)
//   Parameters: IN_W, DIGITS, VSYNC_POL (1 = vsync active-high).
//   Build option: define LEADING_ZERO_BLANK_EN to show leading zeros as
//   BLANK_CODE (units digit is never blanked).
// ---------------------------------------------------------------------------
module vga_digit_update_ctrl
  import vga_digit_update_ctrl_pkg::*;
#(
  parameter int IN_W      = IN_W_DEFAULT,
  parameter int DIGITS    = DIGITS_DEFAULT,
  parameter int VSYNC_POL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vga_digit_update_ctrl_if.slave  bus
);

  localparam logic POL = (VSYNC_POL != 0);

  state_t              state;
  state_t              state_next;
  logic                vsync_q;
  logic                vs_edge;
  logic [IN_W-1:0]     src_reg;
  logic [IN_W-1:0]     pend_val;
  logic                pending;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_result;
  logic [4*DIGITS-1:0] commit_val;
  logic [4*DIGITS-1:0] digits_reg;

  vga_digit_update_ctrl_bin2bcd_seq #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state == ST_LOAD),
    .src    (src_reg),
    .done   (conv_done),
    .result (conv_result)
  );

  // vsync_q resets to the active level so a vsync that is already active
  // when reset releases is not mistaken for a fresh frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= POL;
    end else begin
      vsync_q <= bus.vsync;
    end
  end

  assign vs_edge = (vsync_q != POL) && (bus.vsync == POL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A strobe landing in the COMMIT cycle counts as pending right away, so
  // COMMIT reloads on either a stored or a same-cycle value.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (bus.value_valid) state_next = ST_LOAD;
      ST_LOAD:    state_next = ST_CONVERT;
      ST_CONVERT: if (conv_done) state_next = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_edge) state_next = ST_COMMIT;
      ST_COMMIT:  state_next = (pending || bus.value_valid) ? ST_LOAD : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state != ST_IDLE);
    bus.update_done = (state == ST_COMMIT);
  end

  // Source and pending-value capture. In COMMIT a same-cycle strobe is newer
  // than anything stored, so it goes straight into src_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg  <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
    end else if (state == ST_COMMIT) begin
      if (bus.value_valid) begin
        src_reg <= bus.value;
      end else if (pending) begin
        src_reg <= pend_val;
      end
      pending <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.value_valid) begin
        src_reg <= bus.value;
      end
    end else if (bus.value_valid) begin
      pend_val <= bus.value;
      pending  <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; zeros before the first nonzero digit are
  // blanked. The loop stops above d[0] so a zero value still shows "0".
  always_comb begin
    logic seen_nz;
    commit_val = conv_result;
    seen_nz    = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (!seen_nz && (conv_result[4*k +: 4] == 4'd0)) begin
        commit_val[4*k +: 4] = BLANK_CODE;
      end else begin
        seen_nz = 1'b1;
      end
    end
  end
`else
  assign commit_val = conv_result;
`endif

  // Digits are written as the FSM enters COMMIT, so they change on the same
  // cycle update_done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_reg <= '0;
    end else if ((state == ST_WAIT_VS) && vs_edge) begin
      digits_reg <= commit_val;
    end
  end

  assign bus.bcd_digits = digits_reg;

endmodule

// File: tb/tb_vga_digit_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_digit_update_ctrl
//   Self-checking bench for vga_digit_update_ctrl. Two instances run side by
//   side, one with active-high vsync and one with active-low vsync fed the
//   inverted waveform, so both must behave identically.
//   Honours LEADING_ZERO_BLANK_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_vga_digit_update_ctrl;
  import vga_digit_update_ctrl_pkg::*;

  localparam int IN_W   = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = IN_W + 2;

  typedef struct {
    logic [IN_W-1:0]     value;
    logic [4*DIGITS-1:0] expect_digits;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [IN_W-1:0] value_in  = '0;
  logic            vv_in     = 1'b0;
  logic            vs_active = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  vga_digit_update_ctrl_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus_hi ();
  vga_digit_update_ctrl_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus_lo ();

  assign bus_hi.value       = value_in;
  assign bus_hi.value_valid = vv_in;
  assign bus_hi.vsync       = vs_active;
  assign bus_lo.value       = value_in;
  assign bus_lo.value_valid = vv_in;
  assign bus_lo.vsync       = ~vs_active;

  vga_digit_update_ctrl #(.IN_W(IN_W), .DIGITS(DIGITS), .VSYNC_POL(1)) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_hi)
  );

  vga_digit_update_ctrl #(.IN_W(IN_W), .DIGITS(DIGITS), .VSYNC_POL(0)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lo)
  );

  // Decimal rendering of a value: digit k comes from repeated division, and
  // with blanking enabled digit k (k>0) is blank whenever v < 10^k.
  function automatic logic [4*DIGITS-1:0] fmt(input int unsigned v);
    int unsigned x;
`ifdef LEADING_ZERO_BLANK_EN
    int unsigned p;
    p = 1;
`endif
    x   = v;
    fmt = '0;
    for (int k = 0; k < DIGITS; k++) begin
      fmt[4*k +: 4] = 4'(x % 10);
      x = x / 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) fmt[4*k +: 4] = BLANK_CODE;
      p = p * 10;
`endif
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural reference: one job at a time described by its value and the
  // cycle it was accepted; its result may be committed on any frame edge from
  // accept+IN_W+2 onward, with the commit visible the cycle after the edge.
  int unsigned     m_cyc = 0;
  bit              m_have_job = 1'b0;
  logic [IN_W-1:0] m_job_val = '0;
  int unsigned     m_job_t = 0;
  bit              m_pend = 1'b0;
  logic [IN_W-1:0] m_pend_val = '0;
  longint          m_commit_cyc = -1;
  logic [4*DIGITS-1:0] m_shown = '0;
  bit              m_prev_act = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    bit fedge;
    if (!rst_n) begin
      m_cyc        = 0;
      m_have_job   = 1'b0;
      m_pend       = 1'b0;
      m_commit_cyc = -1;
      m_shown      = '0;
      m_prev_act   = 1'b1;
    end else begin
      fedge      = vs_active && !m_prev_act;
      m_prev_act = vs_active;
      if (!m_have_job) begin
        if (vv_in) begin
          m_have_job = 1'b1;
          m_job_val  = value_in;
          m_job_t    = m_cyc;
        end
      end else if (m_commit_cyc == longint'(m_cyc)) begin
        if (vv_in) begin
          m_job_val = value_in;
          m_job_t   = m_cyc;
        end else if (m_pend) begin
          m_job_val = m_pend_val;
          m_job_t   = m_cyc;
        end else begin
          m_have_job = 1'b0;
        end
        m_pend       = 1'b0;
        m_commit_cyc = -1;
      end else begin
        if (vv_in) begin
          m_pend     = 1'b1;
          m_pend_val = value_in;
        end
        if (fedge && (m_cyc >= m_job_t + LAT)) begin
          m_commit_cyc = longint'(m_cyc) + 1;
          m_shown      = fmt(m_job_val);
        end
      end
      m_cyc++;
    end
  end

  // Every cycle both instances are compared against the reference.
  always @(negedge clk) begin
    checkOutput("model_digits_hi", 32'(bus_hi.bcd_digits), 32'(m_shown));
    checkOutput("model_busy_hi", 32'(bus_hi.busy), 32'(m_have_job));
    checkOutput("model_done_hi", 32'(bus_hi.update_done), 32'(m_commit_cyc == longint'(m_cyc)));
    checkOutput("model_digits_lo", 32'(bus_lo.bcd_digits), 32'(m_shown));
    checkOutput("model_busy_lo", 32'(bus_lo.busy), 32'(m_have_job));
    checkOutput("model_done_lo", 32'(bus_lo.update_done), 32'(m_commit_cyc == longint'(m_cyc)));
    if (bus_hi.update_done) done_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe a value for one cycle; returns one cycle after the strobe cycle.
  task automatic applyStimulus(input logic [IN_W-1:0] v);
    value_in = v;
    vv_in    = 1'b1;
    step(1);
    vv_in    = 1'b0;
  endtask

  // Frame edge in the current cycle; returns in the following cycle.
  task automatic pulseVsync();
    vs_active = 1'b1;
    step(1);
    vs_active = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int d0;
    vecs[0] = '{16'd12345, 20'h12345};
    vecs[1] = '{16'd65535, 20'h65535};
    vecs[2] = '{16'd10000, 20'h10000};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'd0,    20'hFFFF0};
    vecs[4] = '{16'd907,  20'hFF907};
    vecs[5] = '{16'd9,    20'hFFFF9};
    vecs[6] = '{16'd4020, 20'hF4020};
`else
    vecs[3] = '{16'd0,    20'h00000};
    vecs[4] = '{16'd907,  20'h00907};
    vecs[5] = '{16'd9,    20'h00009};
    vecs[6] = '{16'd4020, 20'h04020};
`endif

    step(3);
    rst_n = 1'b1;
    step(1);
    @(negedge clk);
    checkOutput("reset_digits", 32'(bus_hi.bcd_digits), 32'h0);
    checkOutput("reset_busy", 32'(bus_hi.busy), 32'h0);
    checkOutput("reset_done", 32'(bus_hi.update_done), 32'h0);

    // Long wait with no frame edge: nothing may be committed.
    applyStimulus(16'd12345);
    step(99);
    @(negedge clk);
    checkOutput("hold_digits", 32'(bus_hi.bcd_digits), 32'h0);
    checkOutput("hold_busy", 32'(bus_hi.busy), 32'h1);
    d0 = done_seen;
    pulseVsync();
    @(negedge clk);
    checkOutput("s1_digits_hi", 32'(bus_hi.bcd_digits), 32'(fmt(12345)));
    checkOutput("s1_digits_lo", 32'(bus_lo.bcd_digits), 32'(fmt(12345)));
    step(3);
    checkOutput("s1_done_once", 32'(done_seen - d0), 32'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].value);
      step(LAT);
      pulseVsync();
      @(negedge clk);
      checkOutput("vec_digits_hi", 32'(bus_hi.bcd_digits), 32'(vecs[i].expect_digits));
      checkOutput("vec_digits_lo", 32'(bus_lo.bcd_digits), 32'(vecs[i].expect_digits));
      checkOutput("vec_done", 32'(bus_hi.update_done), 32'h1);
      step(2);
    end

    // Edge one cycle before the result is ready is ignored.
    applyStimulus(16'd12);
    step(16);
    d0 = done_seen;
    pulseVsync();
    step(4);
    checkOutput("early_edge_ignored", 32'(done_seen - d0), 32'd0);
    pulseVsync();
    @(negedge clk);
    checkOutput("late_edge_commit", 32'(bus_hi.bcd_digits), 32'(fmt(12)));
    step(2);

    // Edge exactly at strobe+18 commits at strobe+19.
    applyStimulus(16'd65535);
    step(17);
    pulseVsync();
    @(negedge clk);
    checkOutput("lat_done", 32'(bus_hi.update_done), 32'h1);
    checkOutput("lat_digits", 32'(bus_hi.bcd_digits), 32'(fmt(65535)));
    step(2);

    // Strobes during CONVERT: first value commits, latest pending follows.
    applyStimulus(16'd111);
    step(2);
    applyStimulus(16'd222);
    step(2);
    applyStimulus(16'd333);
    step(12);
    pulseVsync();
    @(negedge clk);
    checkOutput("pend_first", 32'(bus_hi.bcd_digits), 32'(fmt(111)));
    step(1);
    checkOutput("pend_reload_busy", 32'(bus_hi.busy), 32'h1);
    step(LAT + 2);
    pulseVsync();
    @(negedge clk);
    checkOutput("pend_latest", 32'(bus_hi.bcd_digits), 32'(fmt(333)));
    step(2);
    checkOutput("pend_idle", 32'(bus_hi.busy), 32'h0);

    // Strobe during the COMMIT cycle is held for the next frame.
    applyStimulus(16'd42);
    step(LAT);
    vs_active = 1'b1;
    step(1);
    vs_active = 1'b0;
    value_in  = 16'd500;
    vv_in     = 1'b1;
    step(1);
    vv_in     = 1'b0;
    step(LAT + 3);
    @(negedge clk);
    checkOutput("commit_strobe_held", 32'(bus_hi.bcd_digits), 32'(fmt(42)));
    pulseVsync();
    @(negedge clk);
    checkOutput("commit_strobe_shown", 32'(bus_hi.bcd_digits), 32'(fmt(500)));
    step(2);

    // Async reset mid-CONVERT and mid-WAIT_VS.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(16'd4321);
      step(r == 0 ? 5 : LAT + 2);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_digits", 32'(bus_hi.bcd_digits), 32'h0);
      checkOutput("async_rst_busy", 32'(bus_hi.busy), 32'h0);
      checkOutput("async_rst_digits_lo", 32'(bus_lo.bcd_digits), 32'h0);
      step(2);
      rst_n = 1'b1;
      step(3);
      d0 = done_seen;
      pulseVsync();
      step(3);
      checkOutput("post_rst_no_commit", 32'(done_seen - d0), 32'd0);
      checkOutput("post_rst_digits", 32'(bus_hi.bcd_digits), 32'h0);
    end

    // Randomised traffic against the reference model.
    begin
      int frame_cnt;
      frame_cnt = 20;
      for (int c = 0; c < 3000; c++) begin
        vv_in = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 0) value_in = IN_W'($urandom_range(0, 120));
        else value_in = IN_W'($urandom_range(0, 65535));
        if (frame_cnt == 0) begin
          vs_active = 1'b1;
          frame_cnt = $urandom_range(8, 40);
        end else begin
          vs_active = 1'b0;
          frame_cnt--;
        end
        step(1);
      end
      vv_in     = 1'b0;
      vs_active = 1'b0;
      step(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
